canvas_buffer: RTL and testbench

Parametrised, multi-bit-colour drawing canvas for the cursor-paint design. Holds an NX×NY framebuffer of COLOR_W-bit pixels in a single-write-port array and accepts paint, erase, toggle and clear-all commands at the cursor position through a valid/ready handshake. A registered read port lets the VGA scan-out logic fetch any pixel independently of drawing. This block replaces the one-flop-per-pixel grid with its flattened output bus.

---
 rtl/canvas_buffer.sv | 153 +++++++++++++++
 tb/tb_canvas_buffer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/canvas_buffer.sv
// NX x NY framebuffer of COLOR_W-bit pixels with paint/erase/toggle/clear-all
// commands at the cursor and an independent registered scan-out read port.
module canvas_buffer #(
    parameter int unsigned NX      = 32,
    parameter int unsigned NY      = 24,
    parameter int unsigned XW      = 5,
    parameter int unsigned YW      = 5,
    parameter int unsigned COLOR_W = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [XW-1:0]      cursor_x,
    input  logic [YW-1:0]      cursor_y,
    input  logic               cmd_valid,
    input  logic [1:0]         cmd_op,
    input  logic [COLOR_W-1:0] cmd_color,
    output logic               cmd_ready,
    output logic               busy,
    input  logic [XW-1:0]      rd_x,
    input  logic [YW-1:0]      rd_y,
    output logic [COLOR_W-1:0] rd_data
);

    localparam int unsigned NPIX = NX * NY;
    localparam int unsigned AW   = $clog2(NPIX);
    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

    localparam logic [1:0] OP_PAINT  = 2'b00;
    localparam logic [1:0] OP_ERASE  = 2'b01;
    localparam logic [1:0] OP_TOGGLE = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        TOGGLE_WR
    } state_t;

    state_t state, state_n;

    logic [COLOR_W-1:0] mem [NPIX];

    logic [AW-1:0]      clr_addr, clr_addr_n;
    logic [AW-1:0]      tog_addr, tog_addr_n;
    logic               tog_ok, tog_ok_n;
    logic [COLOR_W-1:0] tog_data, tog_data_n;

    logic               we;
    logic [AW-1:0]      wa;
    logic [COLOR_W-1:0] wd;

    logic               cur_ok, rd_ok;
    logic [AW-1:0]      cur_addr, rd_addr;

    // Address decode; out-of-range coordinates never touch the array.
    assign cur_ok   = (32'(cursor_x) < NX) && (32'(cursor_y) < NY);
    assign cur_addr = AW'(32'(cursor_y) * NX + 32'(cursor_x));
    assign rd_ok    = (32'(rd_x) < NX) && (32'(rd_y) < NY);
    assign rd_addr  = AW'(32'(rd_y) * NX + 32'(rd_x));

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= CLEAR;
            clr_addr  <= '0;
            tog_addr  <= '0;
            tog_ok    <= 1'b0;
            tog_data  <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
        end else begin
            state     <= state_n;
            clr_addr  <= clr_addr_n;
            tog_addr  <= tog_addr_n;
            tog_ok    <= tog_ok_n;
            tog_data  <= tog_data_n;
            cmd_ready <= (state_n == IDLE);
            busy      <= (state_n != IDLE);
        end
    end

    always_comb begin
        state_n    = state;
        clr_addr_n = clr_addr;
        tog_addr_n = tog_addr;
        tog_ok_n   = tog_ok;
        tog_data_n = tog_data;
        we         = 1'b0;
        wa         = '0;
        wd         = '0;
        case (state)
            CLEAR: begin
                we = 1'b1;
                wa = clr_addr;
                if (clr_addr == LAST_ADDR) begin
                    state_n    = IDLE;
                    clr_addr_n = '0;
                end else begin
                    clr_addr_n = clr_addr + AW'(1);
                end
            end
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_PAINT: begin
                            we = cur_ok;
                            wa = cur_addr;
                            wd = cmd_color;
                        end
                        OP_ERASE: begin
                            we = cur_ok;
                            wa = cur_addr;
                        end
                        OP_TOGGLE: begin
                            tog_addr_n = cur_addr;
                            tog_ok_n   = cur_ok;
                            tog_data_n = cur_ok ? mem[cur_addr] : '0;
                            state_n    = TOGGLE_WR;
                        end
                        OP_CLEAR: begin
                            clr_addr_n = '0;
                            state_n    = CLEAR;
                        end
                        default: ;
                    endcase
                end
            end
            TOGGLE_WR: begin
                we      = tog_ok;
                wa      = tog_addr;
                wd      = ~tog_data;
                state_n = IDLE;
            end
            default: state_n = CLEAR;
        endcase
    end

    // Reset wins over any write, so a pending toggle write is dropped.
    always_ff @(posedge clock) begin
        if (we && !reset) begin
            mem[wa] <= wd;
        end
    end

    // Scan-out read, read-before-write against the command port.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_ok ? mem[rd_addr] : '0;
        end
    end

endmodule

// File: tb/tb_canvas_buffer.sv
// Directed bench for canvas_buffer: vector table plus hand-written multi-cycle sequences.
module tb_canvas_buffer;

    localparam int NX   = 32;
    localparam int NY   = 24;
    localparam int XW   = 6;
    localparam int YW   = 5;
    localparam int CW   = 3;
    localparam int NPIX = NX * NY;

    localparam logic [1:0] OP_PAINT  = 2'b00;
    localparam logic [1:0] OP_ERASE  = 2'b01;
    localparam logic [1:0] OP_TOGGLE = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [XW-1:0] cursor_x = '0;
    logic [YW-1:0] cursor_y = '0;
    logic          cmd_valid = 1'b0;
    logic [1:0]    cmd_op = '0;
    logic [CW-1:0] cmd_color = '0;
    logic          cmd_ready;
    logic          busy;
    logic [XW-1:0] rd_x = '0;
    logic [YW-1:0] rd_y = '0;
    logic [CW-1:0] rd_data;

    int checks   = 0;
    int failures = 0;

    canvas_buffer #(
        .NX(NX), .NY(NY), .XW(XW), .YW(YW), .COLOR_W(CW)
    ) dut (
        .clock(clock), .reset(reset),
        .cursor_x(cursor_x), .cursor_y(cursor_y),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_color(cmd_color),
        .cmd_ready(cmd_ready), .busy(busy),
        .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] op;
        int x;
        int y;
        int color;
        int rx;
        int ry;
        int exp;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic rd(input int x, input int y, output int v);
        rd_x = XW'(x);
        rd_y = YW'(y);
        step();
        v = int'(rd_data);
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!cmd_ready && n < 2000) begin
            step();
            n++;
        end
        if (!cmd_ready) chk(name, 0, 1);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 2000) begin
            step();
            n++;
        end
    endtask

    task automatic issue(input logic [1:0] op, input int x, input int y, input int c);
        wait_ready("issue_timeout");
        cmd_valid = 1'b1;
        cmd_op    = op;
        cursor_x  = XW'(x);
        cursor_y  = YW'(y);
        cmd_color = CW'(c);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic read_all_zero(input string name);
        int bad = 0;
        int v;
        for (int y = 0; y < NY; y++) begin
            for (int x = 0; x < NX; x++) begin
                rd(x, y, v);
                if (v != 0) bad++;
            end
        end
        chk(name, bad, 0);
    endtask

    initial begin
        vec_t tbl[14];
        int v;
        int n;
        int ready_hi;

        tbl[0]  = '{OP_PAINT,  3,  2, 5,  3,  2, 5};
        tbl[1]  = '{OP_ERASE,  3,  2, 0,  3,  2, 0};
        tbl[2]  = '{OP_PAINT,  4,  4, 2,  4,  4, 2};
        tbl[3]  = '{OP_TOGGLE, 4,  4, 0,  4,  4, 5};
        tbl[4]  = '{OP_TOGGLE, 4,  4, 0,  4,  4, 2};
        tbl[5]  = '{OP_PAINT,  0,  1, 4,  0,  1, 4};
        tbl[6]  = '{OP_PAINT,  32, 0, 7,  0,  1, 4};
        tbl[7]  = '{OP_ERASE,  32, 0, 0,  0,  1, 4};
        tbl[8]  = '{OP_PAINT,  0, 24, 7, 32,  0, 0};
        tbl[9]  = '{OP_TOGGLE, 32, 0, 0,  0,  1, 4};
        tbl[10] = '{OP_PAINT,  0,  0, 1,  0,  0, 1};
        tbl[11] = '{OP_PAINT,  31, 0, 3, 31,  0, 3};
        tbl[12] = '{OP_PAINT,  0, 23, 6,  0, 23, 6};
        tbl[13] = '{OP_TOGGLE, 0, 23, 0,  0, 23, 1};

        // Reset state and power-up sweep length
        step();
        step();
        chk("reset_busy", int'(busy), 1);
        chk("reset_ready", int'(cmd_ready), 0);
        chk("reset_rd_data", int'(rd_data), 0);
        reset = 1'b0;
        count_busy(n);
        chk("powerup_busy_cycles", n, NPIX);
        chk("powerup_ready", int'(cmd_ready), 1);
        read_all_zero("powerup_all_zero");

        // Back-to-back paint/erase/paint with ready held
        wait_ready("b2b_timeout");
        ready_hi = 0;
        cmd_valid = 1'b1;
        cmd_op = OP_PAINT; cursor_x = 6'd3;  cursor_y = 5'd2;  cmd_color = 3'd5;
        ready_hi += int'(cmd_ready);
        step();
        cmd_op = OP_ERASE; cursor_x = 6'd3;  cursor_y = 5'd2;  cmd_color = 3'd0;
        ready_hi += int'(cmd_ready);
        step();
        cmd_op = OP_PAINT; cursor_x = 6'd31; cursor_y = 5'd23; cmd_color = 3'd7;
        ready_hi += int'(cmd_ready);
        step();
        cmd_valid = 1'b0;
        ready_hi += int'(cmd_ready);
        chk("b2b_ready_cycles", ready_hi, 4);
        rd(3, 2, v);   chk("b2b_rd_3_2", v, 0);
        rd(31, 23, v); chk("b2b_rd_31_23", v, 7);
        rd(0, 0, v);   chk("b2b_rd_0_0", v, 0);

        // Vector table: one command, then read back once the block is ready
        for (int i = 0; i < 14; i++) begin
            issue(tbl[i].op, tbl[i].x, tbl[i].y, tbl[i].color);
            wait_ready("vec_ready_timeout");
            rd(tbl[i].rx, tbl[i].ry, v);
            chk($sformatf("vec%0d", i), v, tbl[i].exp);
        end

        // Toggle with valid held; cursor moves during TOGGLE_WR without effect
        wait_ready("tog_timeout");
        cmd_valid = 1'b1;
        cmd_op = OP_TOGGLE; cursor_x = 6'd4; cursor_y = 5'd4;
        chk("tog_ready_accept", int'(cmd_ready), 1);
        step();
        cursor_x = 6'd0; cursor_y = 5'd0;
        chk("tog_ready_low", int'(cmd_ready), 0);
        chk("tog_busy", int'(busy), 1);
        step();
        cmd_valid = 1'b0;
        chk("tog_ready_back", int'(cmd_ready), 1);
        chk("tog_busy_done", int'(busy), 0);
        rd(4, 4, v); chk("tog_rd_4_4", v, 5);
        rd(0, 0, v); chk("tog_rd_0_0_untouched", v, 1);
        issue(OP_TOGGLE, 4, 4, 0);
        wait_ready("tog2_timeout");
        rd(4, 4, v); chk("tog2_rd_4_4", v, 2);

        // Same-cycle paint and read of one pixel returns the old value
        wait_ready("rbw_timeout");
        rd_x = 6'd1; rd_y = 5'd1;
        cmd_valid = 1'b1; cmd_op = OP_PAINT; cursor_x = 6'd1; cursor_y = 5'd1; cmd_color = 3'd6;
        step();
        cmd_valid = 1'b0;
        chk("rbw_old", int'(rd_data), 0);
        step();
        chk("rbw_new", int'(rd_data), 6);

        // Clear-all timing and result
        issue(OP_CLEAR, 0, 0, 0);
        count_busy(n);
        chk("clear_busy_cycles", n, NPIX);
        chk("clear_ready", int'(cmd_ready), 1);
        read_all_zero("clear_all_zero");

        // Reset in the middle of a sweep restarts it from zero
        issue(OP_PAINT, 7, 7, 3);
        issue(OP_PAINT, 20, 10, 5);
        wait_ready("mid_ready_timeout");
        rd(20, 10, v); chk("mid_painted", v, 5);
        issue(OP_CLEAR, 0, 0, 0);
        for (int i = 0; i < 100; i++) step();
        chk("mid_busy_at_100", int'(busy), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_reset_ready", int'(cmd_ready), 0);
        count_busy(n);
        chk("mid_restart_busy_cycles", n, NPIX);
        read_all_zero("mid_all_zero");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
